// File: rtl/rx_sync_sequencer.sv
// RX sync sequencer: master delay/pin/align timing or slave sync capture, producing a one-cycle sync_rx.
// Defining RX_SYNC_TIMEOUT_EN adds a 24-bit WAIT_SLV timeout that sets status[3].
module rx_sync_sequencer #(
    parameter logic [6:0] CTRL_ADDR  = 7'd80,
    parameter logic [6:0] DELAY_ADDR = 7'd81,
    parameter int         PIN_WIDTH  = 4,
    parameter int         ALIGN_LAT  = 3
) (
    input  logic        master_clk,
    input  logic        reset,
    input  logic [6:0]  serial_addr,
    input  logic [31:0] serial_data,
    input  logic        serial_strobe,
    input  logic        rx_slave_sync,
    output logic        sync_rx,
    output logic        sync_out_pin,
    output logic        busy,
    output logic [15:0] status
);
    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_DELAY    = 3'd1;
    localparam logic [2:0] S_PIN      = 3'd2;
    localparam logic [2:0] S_ALIGN    = 3'd3;
    localparam logic [2:0] S_WAIT_SLV = 3'd4;
    localparam logic [2:0] S_PULSE    = 3'd5;

    // The PIN/ALIGN phase ends on whichever of the pin window or the align point comes last.
    localparam int         LAST_PHASE   = (PIN_WIDTH - 1 > ALIGN_LAT) ? PIN_WIDTH - 1 : ALIGN_LAT;
    localparam logic [7:0] C_LAST_PHASE = 8'(LAST_PHASE);
    localparam logic [7:0] C_ALIGN_LAT  = 8'(ALIGN_LAT);
    localparam logic [7:0] C_PIN_WIDTH  = 8'(PIN_WIDTH);

    logic [2:0]  r_state, w_state_nx;
    logic [15:0] r_d, r_cnt;
    logic [7:0]  r_phase, w_phase_inc;
    logic [7:0]  r_count;
    logic        r_master, r_slave;
    logic        r_sync1, r_sync2, r_sync3;
    logic        r_done, r_timeout;
    logic        w_ctrl_wr, w_dly_wr, w_arm, w_abort, w_clr;
    logic        w_master, w_slave, w_rise, w_timeout_hit, w_sync_rx, w_in_pa;
    logic        w_unused;

    assign w_ctrl_wr   = serial_strobe && (serial_addr == CTRL_ADDR);
    assign w_dly_wr    = serial_strobe && (serial_addr == DELAY_ADDR);
    assign w_arm       = w_ctrl_wr && serial_data[0];
    assign w_abort     = w_ctrl_wr && serial_data[3];
    assign w_clr       = w_ctrl_wr && serial_data[4];
    // ARM acts on the mode bits carried by the same control write.
    assign w_master    = w_ctrl_wr ? serial_data[1] : r_master;
    assign w_slave     = w_ctrl_wr ? serial_data[2] : r_slave;
    assign w_rise      = r_sync2 && !r_sync3;
    assign w_phase_inc = r_phase + 8'd1;
    assign w_in_pa     = (r_state == S_PIN) || (r_state == S_ALIGN);
    assign w_unused    = ^serial_data[31:16];

`ifdef RX_SYNC_TIMEOUT_EN
    logic [23:0] r_to_cnt;
    always_ff @(posedge master_clk) begin
        if (reset || r_state != S_WAIT_SLV) r_to_cnt <= 24'd0;
        else                                r_to_cnt <= r_to_cnt + 24'd1;
    end
    assign w_timeout_hit = (r_state == S_WAIT_SLV) && (r_to_cnt == 24'hFFFFFE);
`else
    assign w_timeout_hit = 1'b0;
`endif

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_arm) begin
                    if (w_master)     w_state_nx = S_DELAY;
                    else if (w_slave) w_state_nx = S_WAIT_SLV;
                end
            end
            S_DELAY:  if (r_cnt == 16'd0) w_state_nx = S_PIN;
            S_PIN, S_ALIGN: begin
                if (r_phase == C_LAST_PHASE)       w_state_nx = S_IDLE;
                else if (w_phase_inc < C_PIN_WIDTH) w_state_nx = S_PIN;
                else                                w_state_nx = S_ALIGN;
            end
            S_WAIT_SLV: begin
                if (w_rise)             w_state_nx = S_PULSE;
                else if (w_timeout_hit) w_state_nx = S_IDLE;
            end
            S_PULSE:  w_state_nx = S_IDLE;
            default:  w_state_nx = S_IDLE;
        endcase
        if (w_abort) w_state_nx = S_IDLE;
    end

    assign w_sync_rx = (w_in_pa && r_phase == C_ALIGN_LAT) || (r_state == S_PULSE);

    always_ff @(posedge master_clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_d       <= 16'd0;
            r_cnt     <= 16'd0;
            r_phase   <= 8'd0;
            r_master  <= 1'b0;
            r_slave   <= 1'b0;
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_sync3   <= 1'b0;
            r_count   <= 8'd0;
            r_done    <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_sync1 <= rx_slave_sync;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
            if (w_dly_wr) r_d <= serial_data[15:0];
            if (w_ctrl_wr) begin
                r_master <= serial_data[1];
                r_slave  <= serial_data[2];
            end
            // The delay counter tracks D while idle so it is already loaded on entry to DELAY.
            if (r_state == S_IDLE)       r_cnt <= r_d;
            else if (r_state == S_DELAY) r_cnt <= r_cnt - 16'd1;
            r_phase <= w_in_pa ? w_phase_inc : 8'd0;
            if (w_clr) begin
                r_count   <= 8'd0;
                r_done    <= 1'b0;
                r_timeout <= 1'b0;
            end else begin
                if (w_sync_rx) begin
                    r_count <= r_count + 8'd1;
                    r_done  <= 1'b1;
                end
                if (w_timeout_hit && !w_rise) r_timeout <= 1'b1;
            end
        end
    end

    assign sync_rx      = w_sync_rx;
    assign sync_out_pin = (r_state == S_PIN);
    assign busy         = (r_state != S_IDLE);
    assign status       = {r_count, 3'b000, r_done, r_timeout, r_state};

endmodule

// File: tb/tb_rx_sync_sequencer.sv
// Self-checking bench for rx_sync_sequencer: timeline-based reference model plus directed and random scenarios.
module tb_rx_sync_sequencer;
    localparam int         PW    = 4;
    localparam int         AL    = 3;
    localparam logic [6:0] CTRL  = 7'd80;
    localparam logic [6:0] DLY   = 7'd81;
    localparam int         BIG   = 32'h3FFF_FFFF;

    logic        master_clk = 1'b0;
    logic        reset;
    logic [6:0]  serial_addr;
    logic [31:0] serial_data;
    logic        serial_strobe;
    logic        rx_slave_sync;
    logic        sync_rx, sync_out_pin, busy;
    logic [15:0] status;

    rx_sync_sequencer #(
        .CTRL_ADDR(CTRL), .DELAY_ADDR(DLY), .PIN_WIDTH(PW), .ALIGN_LAT(AL)
    ) dut (
        .master_clk(master_clk), .reset(reset), .serial_addr(serial_addr),
        .serial_data(serial_data), .serial_strobe(serial_strobe),
        .rx_slave_sync(rx_slave_sync), .sync_rx(sync_rx), .sync_out_pin(sync_out_pin),
        .busy(busy), .status(status)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 master_clk = ~master_clk;
    int cyc = 0;
    always @(posedge master_clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d (0x%0h) expected %0d (0x%0h)", nm, cyc, act, act, exp, exp);
        end
    endtask

    // ---------------- reference model (absolute-cycle timeline) ----------------
    int         m_bf = 1, m_bu = 0, m_dly_hi = -1, m_pin_lo = 1, m_pin_hi = 0, m_rx_at = -1;
    bit         m_is_slave = 1'b0, m_waiting = 1'b0, m_rx_prev = 1'b0, m_done = 1'b0;
    logic [15:0] m_d = 16'd0;
    logic [7:0]  m_cnt = 8'd0;

    function automatic bit exp_busy(input int n);
        return (n >= m_bf) && (n <= m_bu);
    endfunction
    function automatic bit exp_pin(input int n);
        return exp_busy(n) && (n >= m_pin_lo) && (n <= m_pin_hi);
    endfunction
    function automatic bit exp_rx(input int n);
        return exp_busy(n) && (n == m_rx_at);
    endfunction
    // State numbering follows the listed order IDLE, DELAY, PIN, ALIGN, WAIT_SLV, PULSE.
    function automatic int exp_state(input int n);
        if (!exp_busy(n))  return 0;
        if (m_is_slave)    return (n == m_rx_at) ? 5 : 4;
        if (n <= m_dly_hi) return 1;
        if (exp_pin(n))    return 2;
        return 3;
    endfunction

    task automatic model_cut(input int n);
        if (m_bu > n)     m_bu = n;
        if (m_pin_hi > n) m_pin_hi = n;
        if (m_rx_at > n)  m_rx_at = -1;
        m_waiting = 1'b0;
    endtask

    task automatic model_step(input int n);
        int d;
        d = int'(m_d);
        if (reset) begin
            model_cut(n);
            m_d = 16'd0; m_cnt = 8'd0; m_done = 1'b0; m_rx_prev = 1'b0;
        end else begin
            if (exp_rx(n)) begin m_cnt = m_cnt + 8'd1; m_done = 1'b1; end
            if (serial_strobe && serial_addr == CTRL) begin
                if (serial_data[4]) begin m_cnt = 8'd0; m_done = 1'b0; end
                if (serial_data[3]) model_cut(n);
                else if (serial_data[0] && !exp_busy(n)) begin
                    if (serial_data[1]) begin
                        m_is_slave = 1'b0; m_bf = n + 1; m_dly_hi = n + 1 + d;
                        m_pin_lo = n + 2 + d; m_pin_hi = n + 1 + d + PW; m_rx_at = n + 2 + d + AL;
                        m_bu = (m_pin_hi > m_rx_at) ? m_pin_hi : m_rx_at;
                    end else if (serial_data[2]) begin
                        m_is_slave = 1'b1; m_waiting = 1'b1; m_bf = n + 1; m_bu = BIG;
                        m_dly_hi = -1; m_pin_lo = 1; m_pin_hi = 0; m_rx_at = -1;
                    end
                end
            end
            if (serial_strobe && serial_addr == DLY) m_d = serial_data[15:0];
            if (rx_slave_sync && !m_rx_prev && m_waiting) begin
                m_rx_at = n + 3; m_bu = n + 3; m_waiting = 1'b0;
            end
            m_rx_prev = rx_slave_sync;
        end
    endtask

    // ---------------- per-cycle compare against the model ----------------
    always @(negedge master_clk) begin
        if (chk_en) begin
            chk("busy",         int'(busy),         int'(exp_busy(cyc)));
            chk("sync_out_pin", int'(sync_out_pin), int'(exp_pin(cyc)));
            chk("sync_rx",      int'(sync_rx),      int'(exp_rx(cyc)));
            chk("status",       int'(status),       int'({m_cnt, 3'b000, m_done, 1'b0, 3'(exp_state(cyc))}));
        end
        model_step(cyc);
    end

    // ---------------- event monitor for hand-computed timing checks ----------------
    int last_rx_cyc = -1, pin_rise_cyc = -1, pin_fall_cyc = -1, rx_total = 0, pin_total = 0;
    bit pin_prev = 1'b0;
    always @(negedge master_clk) begin
        if (sync_rx) begin last_rx_cyc = cyc; rx_total++; end
        if (sync_out_pin && !pin_prev) pin_rise_cyc = cyc;
        if (!sync_out_pin && pin_prev) pin_fall_cyc = cyc;
        if (sync_out_pin) pin_total++;
        pin_prev = sync_out_pin;
    end

    // ---------------- driver tasks ----------------
    task automatic idle(input int n);
        repeat (n) @(posedge master_clk);
        #1;
    endtask

    task automatic wr(input logic [6:0] a, input logic [31:0] d);
        serial_addr = a; serial_data = d; serial_strobe = 1'b1;
        idle(1);
        serial_strobe = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int k;
        k = 0;
        while (busy && k < budget) begin idle(1); k++; end
        chk("wait_idle_budget", int'(busy), 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int a, k, p0, r0;
        reset = 1'b1; serial_addr = '0; serial_data = '0; serial_strobe = 1'b0; rx_slave_sync = 1'b0;
        idle(3);
        chk_en = 1'b1;
        chk("reset_status", int'(status), 0);
        chk("reset_busy", int'(busy), 0);
        reset = 1'b0;
        idle(2);

        // Master, D=5
        wr(DLY, 32'd5); idle(2);
        a = cyc; wr(CTRL, 32'h03);
        wait_idle(100); idle(2);
        chk("m5_pin_first", pin_rise_cyc - a, 7);
        chk("m5_pin_last", pin_fall_cyc - 1 - a, 10);
        chk("m5_rx_cycle", last_rx_cyc - a, 10);
        chk("m5_count", int'(status[15:8]), 1);
        chk("m5_done", int'(status[4]), 1);

        // Slave, clean rise
        wr(CTRL, 32'h05); idle(10);
        k = cyc; rx_slave_sync = 1'b1;
        wait_idle(50); idle(2);
        chk("slv_rx_cycle", last_rx_cyc - k, 3);
        rx_slave_sync = 1'b0; idle(5);

        // Slave with input already high: no trigger
        rx_slave_sync = 1'b1; idle(6);
        r0 = rx_total; wr(CTRL, 32'h05); idle(30);
        chk("slv_held_busy", int'(busy), 1);
        chk("slv_held_norx", rx_total - r0, 0);
        wr(CTRL, 32'h08); idle(1);
        chk("slv_held_abort", int'(busy), 0);
        rx_slave_sync = 1'b0; idle(5);

        // Master D=1000 aborted at 500
        wr(DLY, 32'd1000); idle(1);
        p0 = pin_total; r0 = rx_total;
        a = cyc; wr(CTRL, 32'h03);
        idle(a + 500 - cyc);
        wr(CTRL, 32'h08);
        chk("ab_idle_cycle", cyc - a, 501);
        chk("ab_busy", int'(busy), 0);
        idle(1100);
        chk("ab_no_pin", pin_total - p0, 0);
        chk("ab_no_rx", rx_total - r0, 0);

        // Simultaneous ARM+ABORT from IDLE
        wr(CTRL, 32'h0B);
        chk("armabort_busy", int'(busy), 0);
        idle(10);
        chk("armabort_no_pin", pin_total - p0, 0);

        // Master D=0 with a second ARM during PIN
        wr(DLY, 32'd0); idle(1);
        p0 = pin_total;
        a = cyc; wr(CTRL, 32'h03);
        idle(a + 3 - cyc); wr(CTRL, 32'h03);
        wait_idle(50); idle(2);
        chk("d0_pin_first", pin_rise_cyc - a, 2);
        chk("d0_rx_cycle", last_rx_cyc - a, 5);
        chk("d0_pin_total", pin_total - p0, PW);

        // Writes to other addresses
        wr(7'd82, 32'h03); wr(7'd79, 32'h0000_0007); idle(3);
        chk("other_addr_busy", int'(busy), 0);

        // CLR_STATUS
        wr(CTRL, 32'h10); idle(1);
        chk("clr_count", int'(status[15:8]), 0);
        chk("clr_done", int'(status[4]), 0);

        // Reset mid-sequence (during PIN)
        wr(DLY, 32'd10); idle(1);
        r0 = rx_total;
        a = cyc; wr(CTRL, 32'h03);
        idle(a + 13 - cyc);
        reset = 1'b1; idle(1); reset = 1'b0;
        chk("rst_mid_busy", int'(busy), 0);
        chk("rst_mid_pin", int'(sync_out_pin), 0);
        idle(20);
        chk("rst_mid_no_rx", rx_total - r0, 0);

        // Randomized mix
        for (int i = 0; i < 40; i++) begin
            wr(DLY, 32'($urandom_range(0, 30)));
            if ($urandom_range(0, 1) == 1) begin
                wr(CTRL, 32'h03);
                if ($urandom_range(0, 3) == 0) begin
                    idle($urandom_range(0, 35));
                    wr(CTRL, ($urandom_range(0, 1) == 1) ? 32'h0B : 32'h08);
                end else if ($urandom_range(0, 1) == 1) begin
                    idle($urandom_range(0, 30));
                    wr(CTRL, 32'h03);
                end
                wait_idle(200);
            end else begin
                wr(CTRL, 32'h05);
                idle($urandom_range(2, 25));
                if ($urandom_range(0, 3) == 0) wr(CTRL, 32'h08);
                else begin
                    rx_slave_sync = 1'b1; idle($urandom_range(1, 6)); rx_slave_sync = 1'b0;
                end
                wait_idle(200);
            end
            if ($urandom_range(0, 7) == 0) wr(CTRL, 32'h10);
            idle($urandom_range(3, 8));
        end

        // 256 master syncs wrap the counter
        wr(CTRL, 32'h10); wr(DLY, 32'd0);
        for (int i = 0; i < 256; i++) begin
            wr(CTRL, 32'h03);
            wait_idle(50);
        end
        idle(2);
        chk("wrap_count", int'(status[15:8]), 0);
        chk("wrap_done", int'(status[4]), 1);
        chk("timeout_bit", int'(status[3]), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        errors++;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rx_sync_sequencer.md
RX_SYNC_SEQUENCER -- requirements
Module: rx_sync_sequencer

Interface
REQ-001 The block SHALL have a single clock and a reset: one clock; reset is synchronous and active-high.
REQ-002 Parameter CTRL_ADDR, default 7'd80: serial address of the control register.
REQ-003 Parameter DELAY_ADDR, default 7'd81: serial address of the delay register.
REQ-004 Parameter PIN_WIDTH, default 4: sync_out_pin high time, in master_clk cycles (1..15).
REQ-005 Parameter ALIGN_LAT, default 3: master-side compensation delay, in cycles, matching the slave input path.
REQ-006 Ports SHALL be:
 master_clk  in  1  system clock
 reset  in  1  synchronous active-high reset
 serial_addr  in  7  setting bus address
 serial_data  in  32  setting bus data
 serial_strobe  in  1  setting bus write strobe
 rx_slave_sync  in  1  asynchronous sync from master board pin
 sync_rx  out  1  one-cycle RX sync pulse to the DSP chain
 sync_out_pin  out  1  sync drive to slave boards
 busy  out  1  high in any state other than IDLE
 status  out  16  [2:0] state, [3] timeout, [4] done (sticky), [15:8] sync count

Function
REQ-007 Control register write (serial_strobe with serial_addr==CTRL_ADDR) SHALL decode: bit0 ARM, bit1 MASTER, bit2 SLAVE, bit3 ABORT, bit4 CLR_STATUS; ARM, ABORT and CLR_STATUS are one-shot commands, MASTER and SLAVE are held.
REQ-008 Delay register write SHALL latch serial_data[15:0] as D.
REQ-009 States: IDLE, DELAY, PIN, ALIGN, WAIT_SLV, PULSE.
REQ-010 IDLE + ARM with MASTER=1 -> DELAY, counter loaded with D, on the cycle after the strobe.
REQ-011 IDLE + ARM with MASTER=0 and SLAVE=1 -> WAIT_SLV; ARM with both clear is ignored.
REQ-012 DELAY: decrement each cycle; at 0 -> PIN; D=0 gives one DELAY cycle.
REQ-013 Master timing, strobe at cycle 0: sync_out_pin high cycles D+2..D+1+PIN_WIDTH, sync_rx high exactly at cycle D+2+ALIGN_LAT.
REQ-014 Master mode SHALL leave PIN/ALIGN only when both the pin window and the ALIGN_LAT count have expired, then return to IDLE.
REQ-015 rx_slave_sync SHALL pass through a 2-flop synchronizer and a rising-edge detector; an input already high when WAIT_SLV is entered SHALL NOT trigger.
REQ-016 Slave timing: first master_clk edge sampling rx_slave_sync high at cycle k -> sync_rx high exactly at cycle k+3 (PULSE), then IDLE; D is ignored.
REQ-017 ARM while busy SHALL be ignored.
REQ-018 ABORT SHALL force IDLE on the next cycle, deassert sync_out_pin and suppress any pending sync_rx; ABORT wins over a simultaneous ARM.
REQ-019 Each sync_rx pulse SHALL set done and increment sync count (8-bit, wraps 255->0).
REQ-020 CLR_STATUS SHALL clear done, timeout and count.
REQ-021 Register writes to other addresses SHALL have no effect.

Reset
REQ-022 Reset SHALL force IDLE and clear D, MASTER, SLAVE, counters and status; sync_rx, sync_out_pin and busy SHALL be 0.
REQ-023 Reset asserted mid-sequence SHALL abort it with no sync_rx pulse emitted.

Configuration
REQ-024 Macro RX_SYNC_TIMEOUT_EN defined: a 24-bit counter SHALL run in WAIT_SLV; at 2^24-1 cycles, set timeout and go to IDLE without a sync_rx pulse.
REQ-025 Macro RX_SYNC_TIMEOUT_EN undefined: WAIT_SLV SHALL wait indefinitely and status[3] SHALL read 0.

Verification
REQ-026 Master, D=5, ARM at cycle 0 -> sync_out_pin high cycles 7..10, sync_rx at cycle 10, count=1, done=1.
REQ-027 Slave, rx_slave_sync rises and is first sampled at cycle 20 -> sync_rx at cycle 23; rx_slave_sync held high before ARM -> no pulse.
REQ-028 Master, D=1000, ABORT at cycle 500 -> IDLE at 501, no pin, no sync_rx; simultaneous ARM+ABORT from IDLE -> stays IDLE.
REQ-029 Master, D=0 -> pin high at cycle 2, sync_rx at cycle 5; second ARM during PIN is ignored.
REQ-030 256 master syncs -> count wraps to 0 with done=1; with RX_SYNC_TIMEOUT_EN, slave with no input -> timeout=1 after 2^24-1 cycles, busy=0.
